// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to transmitter and receiver),
// default frame geometry and the idle line level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam int   DEFAULT_DATA_BITS  = 8;
  localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous UART inputs; both flops reset to RST_VAL
// so an idle line does not look like a start edge when reset is released.
module uart_sync
  import uart_pkg::*;
#(
  parameter logic RST_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start detection, mid-bit sampling of MSB-first data,
// stop-bit check, and a registered byte with framing/overrun reporting.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] RX_BYTE,
  output logic                 RX_VALID,
  output logic                 RX_BUSY,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 line;
  logic                 shift_en;
  logic                 stop_sample;

  uart_sync #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
    end
  end

  // START waits half a bit to land on mid start bit; DATA/STOP then step a whole bit.
  always_comb begin
    state_next  = state;
    tick_next   = tick_cnt;
    bit_next    = bit_cnt;
    shift_en    = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (rx_enable && !line) begin
          tick_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (rx_tick) begin
          if (tick_cnt == TICK_MID) begin
            if (line) begin
              state_next = IDLE;
            end else begin
              tick_next  = '0;
              bit_next   = '0;
              state_next = DATA;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next = '0;
            shift_en  = 1'b1;
            bit_next  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_next = STOP;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (rx_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next   = '0;
            stop_sample = 1'b1;
            state_next  = IDLE;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[DATA_BITS-2:0], line};
    end
  end

  assign RX_BUSY = (state != IDLE);

  // Handshake: RX_VALID high means RX_BYTE holds an unconsumed byte; rx_ack in a cycle
  // where RX_VALID is high consumes it on that edge (ack ignored while RX_VALID is low).
  // A good stop in the same cycle as a consuming ack loads the new byte without overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RX_BYTE     <= '0;
      RX_VALID    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= stop_sample && !line;
      if (rx_ack && RX_VALID) begin
        RX_VALID <= 1'b0;
        overrun  <= 1'b0;
      end
      if (stop_sample && line) begin
        if (!RX_VALID || rx_ack) begin
          RX_BYTE  <= shift_reg;
          RX_VALID <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames driven bit by bit, expected
// bytes queued at drive time and popped when RX_VALID presents a byte.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int DB = 8;
  // Posedge (counted from the clk whose preceding negedge drives the start bit) of the stop sample.
  localparam int STOP_SAMPLE_CLK = 3 + OS / 2 + OS * (DB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_tick = 1'b0;
  logic          rx_enable = 1'b1;
  logic          rx_in = 1'b1;
  logic          rx_ack = 1'b0;
  logic [DB-1:0] rx_byte;
  logic          rx_valid, rx_busy, framing_err, overrun;

  int checks = 0;
  int fails  = 0;
  logic [DB-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_tick     (rx_tick),
    .rx_enable   (rx_enable),
    .rx_in       (rx_in),
    .rx_ack      (rx_ack),
    .RX_BYTE     (rx_byte),
    .RX_VALID    (rx_valid),
    .RX_BUSY     (rx_busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  // Tick generator: one pulse every tick_div clks.
  int tick_div = 1;
  int tick_phase = 0;
  always @(negedge clk) begin
    rx_tick = (tick_phase == 0);
    tick_phase = (tick_phase + 1 >= tick_div) ? 0 : tick_phase + 1;
  end

  // Monitors: cumulative counts and the length of the last completed pulse.
  int fe_total = 0, fe_run = 0, last_fe_run = 0;
  int busy_total = 0, busy_run = 0, last_busy_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_err) begin
        fe_total++;
        fe_run++;
      end else begin
        if (fe_run != 0) last_fe_run = fe_run;
        fe_run = 0;
      end
      if (rx_busy) begin
        busy_total++;
        busy_run++;
      end else begin
        if (busy_run != 0) last_busy_run = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic drive_line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = v;
    end
  endtask

  // ack_at: frame-relative clk index at which rx_ack is held for one clk (-1 = never).
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int ack_at);
    int bp;
    int b;
    logic [DB-1:0] sh;
    bp = OS * tick_div;
    for (int i = 0; i < 10 * bp; i++) begin
      b = i / bp;
      @(negedge clk);
      sh = d << (b - 1);
      if (b == 0) rx_in = 1'b0;
      else if (b == 9) rx_in = stop;
      else rx_in = sh[DB-1];
      rx_ack = (i == ack_at);
    end
    rx_ack = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic pop_expected(output logic [DB-1:0] e, output bit ok);
    ok = (exp_q.size() != 0);
    e = ok ? exp_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_byte, rx_valid, rx_busy, framing_err, overrun} !== 12'h000) begin
      fails++;
      $display("FAIL reset_values: got %h expected 000", {rx_byte, rx_valid, rx_busy, framing_err, overrun});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_valid, rx_busy} !== 2'b00) begin
      fails++;
      $display("FAIL after_release: valid/busy got %b expected 00", {rx_valid, rx_busy});
    end
  endtask

  task automatic test_single_byte();
    bit ok;
    logic [DB-1:0] e;
    int f0;
    f0 = fe_total;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    drive_line(1'b1, 4);
    wait_valid(ok);
    pop_expected(e, ok);
    checks++;
    if (!ok || !rx_valid || rx_byte !== e) begin
      fails++;
      $display("FAIL single_byte: valid %b byte %h expected valid 1 byte %h", rx_valid, rx_byte, e);
    end
    checks++;
    if (fe_total != f0) begin
      fails++;
      $display("FAIL single_framing: %0d pulses expected 0", fe_total - f0);
    end
    pulse_ack();
    checks++;
    if (rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL ack_clear: valid %b expected 0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    int f0, b0;
    f0 = fe_total;
    b0 = busy_total;
    drive_line(1'b0, 5);
    drive_line(1'b1, 30);
    checks++;
    if ({rx_valid, rx_busy, overrun} !== 3'b000 || fe_total != f0) begin
      fails++;
      $display("FAIL glitch_flags: valid/busy/ovr %b fe %0d expected 000 fe 0",
               {rx_valid, rx_busy, overrun}, fe_total - f0);
    end
    checks++;
    if (busy_total == b0 || last_busy_run < 1 || last_busy_run > OS / 2) begin
      fails++;
      $display("FAIL glitch_busy: run %0d clks expected 1..%0d", last_busy_run, OS / 2);
    end
  endtask

  task automatic test_framing();
    int f0;
    f0 = fe_total;
    send_frame(8'h3C, 1'b0, -1);
    drive_line(1'b1, 30);
    checks++;
    if (fe_total - f0 != 1 || last_fe_run != 1) begin
      fails++;
      $display("FAIL framing_pulse: %0d pulses of %0d clks expected 1 of 1", fe_total - f0, last_fe_run);
    end
    checks++;
    if (rx_valid !== 1'b0 || rx_byte !== 8'hA5) begin
      fails++;
      $display("FAIL framing_hold: valid %b byte %h expected 0 a5", rx_valid, rx_byte);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [DB-1:0] e;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    drive_line(1'b1, 4);
    wait_valid(ok);
    pop_expected(e, ok);
    checks++;
    if (!ok || rx_byte !== e) begin
      fails++;
      $display("FAIL overrun_byte: byte %h expected %h", rx_byte, e);
    end
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun %b expected 1", overrun);
    end
    pulse_ack();
    checks++;
    if ({rx_valid, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL overrun_clear: valid/overrun %b expected 00", {rx_valid, overrun});
    end
  endtask

  task automatic test_simultaneous_ack();
    bit ok;
    logic [DB-1:0] e;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    wait_valid(ok);
    pop_expected(e, ok);
    checks++;
    if (!ok || rx_byte !== e) begin
      fails++;
      $display("FAIL simul_first: byte %h expected %h", rx_byte, e);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, STOP_SAMPLE_CLK - 1);
    drive_line(1'b1, 4);
    pop_expected(e, ok);
    checks++;
    if (!ok || rx_byte !== e || rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL simul_load: valid %b byte %h expected 1 %h", rx_valid, rx_byte, e);
    end
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL simul_overrun: overrun %b expected 0", overrun);
    end
    pulse_ack();
  endtask

  task automatic test_tick_gaps();
    bit ok;
    logic [DB-1:0] e;
    tick_div = 3;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, -1);
    drive_line(1'b1, 10);
    wait_valid(ok);
    pop_expected(e, ok);
    checks++;
    if (!ok || rx_byte !== e) begin
      fails++;
      $display("FAIL tick_gaps: valid %b byte %h expected 1 %h", rx_valid, rx_byte, e);
    end
    pulse_ack();
    tick_div = 1;
    drive_line(1'b1, 4);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [DB-1:0] e;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    wait_valid(ok);
    pop_expected(e, ok);
    checks++;
    if (!ok || rx_byte !== e) begin
      fails++;
      $display("FAIL preload: byte %h expected %h", rx_byte, e);
    end
    send_frame(8'h66, 1'b1, -1);
    drive_line(1'b0, OS);
    drive_line(1'b1, 3 * OS);
    checks++;
    if ({rx_busy, overrun} !== 2'b11) begin
      fails++;
      $display("FAIL pre_reset: busy/overrun %b expected 11", {rx_busy, overrun});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_byte, rx_valid, rx_busy, framing_err, overrun} !== 12'h000) begin
      fails++;
      $display("FAIL mid_reset: got %h expected 000", {rx_byte, rx_valid, rx_busy, framing_err, overrun});
    end
    rst = 1'b0;
    exp_q.delete();
    drive_line(1'b1, 7 * OS);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    drive_line(1'b1, 4);
    wait_valid(ok);
    pop_expected(e, ok);
    checks++;
    if (!ok || rx_byte !== e) begin
      fails++;
      $display("FAIL post_reset_byte: valid %b byte %h expected 1 %h", rx_valid, rx_byte, e);
    end
    pulse_ack();
  endtask

  task automatic test_enable_gating();
    int b0;
    rx_enable = 1'b0;
    b0 = busy_total;
    send_frame(8'h55, 1'b1, -1);
    drive_line(1'b1, 8);
    checks++;
    if (busy_total != b0 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL enable_gate: busy clks %0d valid %b expected 0 0", busy_total - b0, rx_valid);
    end
    rx_enable = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: %0d entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing();
    test_overrun();
    test_simultaneous_ack();
    test_tick_gaps();
    test_reset_mid_frame();
    test_enable_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
